// File: rtl/real_alu_sched_if.sv
// Request/response bundle between two real-valued requesters, the shared ALU
// scheduler and the result consumer.
interface real_alu_sched_if;
    logic       req0_valid;
    logic       req0_ready;
    logic [2:0] req0_op;
    real        req0_a;
    real        req0_b;

    logic       req1_valid;
    logic       req1_ready;
    logic [2:0] req1_op;
    real        req1_a;
    real        req1_b;

    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    real        rsp_result;
    shortreal   rsp_result_sr;
    logic       rsp_flag;
    logic       rsp_err;
    logic       busy;

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_result_sr, rsp_flag, rsp_err, busy
    );

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_result_sr, rsp_flag, rsp_err, busy
    );
endinterface

// File: rtl/real_alu_sched.sv
// Round-robin scheduler for one shared fixed-latency real ALU: accepts one op
// at a time, waits out its latency, and holds the result until consumed.
module real_alu_sched #(
    parameter int LATENCY   = 2,
    parameter int DIV_EXTRA = 4
) (
    input logic              clk,
    input logic              rst,
    real_alu_sched_if.slave  bus
);

    localparam int DIV_LAT = LATENCY + DIV_EXTRA;
    localparam int CW      = $clog2(DIV_LAT + 1);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_GT  = 3'd4;
    localparam logic [2:0] OP_NEG = 3'd5;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state, state_nxt;
    logic            last_gnt;
    logic            gnt_id;
    logic            ready0, ready1, accept, finish;
    logic [2:0]      op_sel;
    real             a_sel, b_sel;
    logic [CW-1:0]   lat_sel;

    logic [2:0]      op_q;
    real             a_q, b_q;
    logic            id_q;
    logic [CW-1:0]   cnt;

    real             c_res;
    logic            c_flag, c_err;

    real             res_q;
    logic            flag_q, err_q, rid_q;

    // Grant goes to the sole valid requester, or on contention to the one not
    // granted last time.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves
        // a signal unassigned and infers a latch.
        gnt_id  = bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid)
            gnt_id = ~last_gnt;
        ready0  = (state == IDLE) && !rst && bus.req0_valid && !gnt_id;
        ready1  = (state == IDLE) && !rst && bus.req1_valid &&  gnt_id;
        accept  = ready0 || ready1;
        op_sel  = gnt_id ? bus.req1_op : bus.req0_op;
        a_sel   = gnt_id ? bus.req1_a  : bus.req0_a;
        b_sel   = gnt_id ? bus.req1_b  : bus.req0_b;
        lat_sel = (op_sel == OP_DIV) ? CW'(DIV_LAT) : CW'(LATENCY);
        finish  = (state == BUSY) && (cnt == CW'(1));
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (accept)        state_nxt = BUSY;
            BUSY:    if (finish)        state_nxt = DONE;
            DONE:    if (bus.rsp_ready) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // Arithmetic on the latched operands; evaluated into the result registers
    // on the final latency cycle.
    always_comb begin
        c_res  = 0.0;
        c_flag = 1'b0;
        c_err  = 1'b0;
        case (op_q)
            OP_ADD: c_res = a_q + b_q;
            OP_SUB: c_res = a_q - b_q;
            OP_MUL: c_res = a_q * b_q;
            OP_DIV: begin
                if (b_q == 0.0) c_err = 1'b1;
                else            c_res = a_q / b_q;
            end
            OP_GT: begin
                c_flag = (a_q > b_q);
                c_res  = c_flag ? 1.0 : 0.0;
            end
            OP_NEG:  c_res = -a_q;
            default: c_err = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= 1'b1;
            op_q     <= 3'd0;
            a_q      <= 0.0;
            b_q      <= 0.0;
            id_q     <= 1'b0;
            cnt      <= '0;
            res_q    <= 0.0;
            flag_q   <= 1'b0;
            err_q    <= 1'b0;
            rid_q    <= 1'b0;
        end else begin
            if (accept) begin
                op_q     <= op_sel;
                a_q      <= a_sel;
                b_q      <= b_sel;
                id_q     <= gnt_id;
                last_gnt <= gnt_id;
                cnt      <= lat_sel;
            end else if (state == BUSY && !finish) begin
                cnt <= cnt - CW'(1);
            end
            if (finish) begin
                res_q  <= c_res;
                flag_q <= c_flag;
                err_q  <= c_err;
                rid_q  <= id_q;
            end
        end
    end

    assign bus.req0_ready    = ready0;
    assign bus.req1_ready    = ready1;
    assign bus.rsp_valid     = (state == DONE);
    assign bus.busy          = (state != IDLE);
    assign bus.rsp_id        = rid_q;
    assign bus.rsp_result    = res_q;
    assign bus.rsp_result_sr = shortreal'(res_q);
    assign bus.rsp_flag      = flag_q;
    assign bus.rsp_err       = err_q;

endmodule

// File: tb/tb_real_alu_sched.sv
// Directed bench for real_alu_sched: a cycle-count reference model checked on
// every falling edge, plus literal expectations for the headline cases.
module tb_real_alu_sched;

    localparam int LAT  = 2;
    localparam int DIVX = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    real_alu_sched_if bus();

    real_alu_sched #(.LATENCY(LAT), .DIV_EXTRA(DIVX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        real  res;
        logic flag;
        logic err;
        logic id;
    } rsp_t;

    // Reference model: one op outstanding, response due a fixed number of
    // cycles after the accepting edge, held until consumed.
    bit   m_out   = 1'b0;
    bit   m_valid = 1'b0;
    bit   m_last  = 1'b1;
    int   m_due   = 0;
    rsp_t m_exp   = '{0.0, 1'b0, 1'b0, 1'b0};
    rsp_t m_shown = '{0.0, 1'b0, 1'b0, 1'b0};

    real  cap_res;
    real  cap_sr;
    logic cap_flag, cap_err, cap_id;
    int   cap_cyc;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_real(input string name, input real act, input real exp, input real tol);
        checks++;
        if ((act - exp > tol) || (exp - act > tol)) begin
            errors++;
            $display("FAIL %s: got %f expected %f (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic rsp_t model_op(input logic [2:0] op, input real a, input real b, input logic id);
        rsp_t r;
        r = '{0.0, 1'b0, 1'b0, id};
        case (op)
            3'd0: r.res = a + b;
            3'd1: r.res = a - b;
            3'd2: r.res = a * b;
            3'd3: if (b == 0.0) r.err = 1'b1; else r.res = a / b;
            3'd4: begin r.flag = (a > b); r.res = r.flag ? 1.0 : 0.0; end
            3'd5: r.res = -a;
            default: r.err = 1'b1;
        endcase
        return r;
    endfunction

    function automatic logic model_grant();
        if (bus.req0_valid && bus.req1_valid) return ~m_last;
        return bus.req1_valid;
    endfunction

    function automatic logic exp_ready(input int id);
        logic v;
        v = (id == 0) ? bus.req0_valid : bus.req1_valid;
        return !rst && !m_out && v && (model_grant() == id[0]);
    endfunction

    always @(posedge clk) begin
        logic g;
        cyc++;
        if (rst) begin
            m_out   = 1'b0;
            m_valid = 1'b0;
            m_last  = 1'b1;
            m_shown = '{0.0, 1'b0, 1'b0, 1'b0};
        end else begin
            if (m_valid) begin
                if (bus.rsp_ready) begin
                    m_valid = 1'b0;
                    m_out   = 1'b0;
                end
            end else if (!m_out && (bus.req0_valid || bus.req1_valid)) begin
                g      = model_grant();
                m_out  = 1'b1;
                m_last = g;
                if (g) begin
                    m_exp = model_op(bus.req1_op, bus.req1_a, bus.req1_b, 1'b1);
                    m_due = cyc + ((bus.req1_op == 3'd3) ? LAT + DIVX : LAT);
                end else begin
                    m_exp = model_op(bus.req0_op, bus.req0_a, bus.req0_b, 1'b0);
                    m_due = cyc + ((bus.req0_op == 3'd3) ? LAT + DIVX : LAT);
                end
            end
            if (m_out && !m_valid && cyc == m_due) begin
                m_valid = 1'b1;
                m_shown = m_exp;
            end
        end
    end

    always @(negedge clk) begin
        check_bit("req0_ready", bus.req0_ready, exp_ready(0));
        check_bit("req1_ready", bus.req1_ready, exp_ready(1));
        check_bit("rsp_valid", bus.rsp_valid, m_valid);
        check_bit("busy", bus.busy, m_out);
        check_bit("rsp_id", bus.rsp_id, m_shown.id);
        check_bit("rsp_flag", bus.rsp_flag, m_shown.flag);
        check_bit("rsp_err", bus.rsp_err, m_shown.err);
        check_real("rsp_result", bus.rsp_result, m_shown.res, 1e-12);
        check_real("rsp_result_sr", real'(bus.rsp_result_sr), real'(shortreal'(m_shown.res)), 1e-6);
    end

    task automatic set_req(input int id, input logic v, input logic [2:0] op, input real a, input real b);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Waits (bounded) for the requester's ready, then returns just after the
    // accepting edge with the cycle index of that edge.
    task automatic wait_ready(input int id, output int acc);
        bit found;
        found = 1'b0;
        acc   = -1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((id == 0 && bus.req0_ready) || (id == 1 && bus.req1_ready)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: requester %0d never granted", id);
        end
        @(posedge clk);
        #1;
        acc = cyc;
    endtask

    task automatic issue(input int id, input logic [2:0] op, input real a, input real b, output int acc);
        set_req(id, 1'b1, op, a, b);
        wait_ready(id, acc);
        set_req(id, 1'b0, op, a, b);
    endtask

    task automatic wait_rsp();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL rsp_timeout: rsp_valid never rose");
        end
        cap_res  = bus.rsp_result;
        cap_sr   = real'(bus.rsp_result_sr);
        cap_flag = bus.rsp_flag;
        cap_err  = bus.rsp_err;
        cap_id   = bus.rsp_id;
        cap_cyc  = cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, h, g, seen;
        set_req(0, 1'b0, 3'd0, 0.0, 0.0);
        set_req(1, 1'b0, 3'd0, 0.0, 0.0);
        bus.rsp_ready = 1'b1;
        rst = 1'b1;

        // Reset state, and no ready while reset is asserted.
        repeat (2) @(posedge clk);
        #1;
        set_req(0, 1'b1, 3'd0, 1.0, 1.0);
        @(negedge clk);
        check_bit("ready_in_reset", bus.req0_ready, 1'b0);
        check_bit("reset_rsp_valid", bus.rsp_valid, 1'b0);
        check_bit("reset_busy", bus.busy, 1'b0);
        check_real("reset_result", bus.rsp_result, 0.0, 0.0);
        check_real("reset_result_sr", real'(bus.rsp_result_sr), 0.0, 0.0);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 3'd0, 0.0, 0.0);
        rst = 1'b0;

        // Round-robin contention: req0 mul, req1 sub, held continuously.
        set_req(0, 1'b1, 3'd2, 3.14, 1.0);
        set_req(1, 1'b1, 3'd1, 100.5, 1.0);
        for (int i = 0; i < 4; i++) begin
            seen = 0;
            for (int k = 0; k < 50; k++) begin
                @(negedge clk);
                if (bus.req0_ready || bus.req1_ready) begin
                    seen = 1;
                    break;
                end
            end
            g = bus.req1_ready ? 1 : 0;
            check_int("rr_grant_seen", seen, 1);
            check_int("rr_grant", g, i % 2);
            wait_rsp();
            check_bit("rr_rsp_id", cap_id, 1'(i % 2));
            check_real("rr_result", cap_res, (i % 2 == 1) ? 99.5 : 3.14, 1e-9);
        end
        set_req(0, 1'b0, 3'd0, 0.0, 0.0);
        set_req(1, 1'b0, 3'd0, 0.0, 0.0);

        // Single add.
        issue(0, 3'd0, 3.14, 1.0, acc);
        wait_rsp();
        check_int("add_latency", cap_cyc - acc, 2);
        check_real("add_result", cap_res, 4.14, 1e-9);
        check_real("add_result_sr", cap_sr, 4.14, 1e-5);
        check_bit("add_id", cap_id, 1'b0);
        check_bit("add_err", cap_err, 1'b0);

        // Divide and divide by zero.
        issue(0, 3'd3, 3.14, 2.0, acc);
        wait_rsp();
        check_int("div_latency", cap_cyc - acc, 6);
        check_real("div_result", cap_res, 1.57, 1e-9);
        check_bit("div_err", cap_err, 1'b0);
        issue(1, 3'd3, 3.14, 0.0, acc);
        wait_rsp();
        check_int("div0_latency", cap_cyc - acc, 6);
        check_bit("div0_err", cap_err, 1'b1);
        check_real("div0_result", cap_res, 0.0, 0.0);

        // Compare, negate, illegal opcode.
        issue(0, 3'd4, 3.14, 1.0, acc);
        wait_rsp();
        check_bit("gt_true_flag", cap_flag, 1'b1);
        check_real("gt_true_result", cap_res, 1.0, 0.0);
        issue(1, 3'd4, 1.0, 3.14, acc);
        wait_rsp();
        check_bit("gt_false_flag", cap_flag, 1'b0);
        check_real("gt_false_result", cap_res, 0.0, 0.0);
        issue(0, 3'd5, 3.14, 7.0, acc);
        wait_rsp();
        check_real("neg_result", cap_res, -3.14, 1e-9);
        check_bit("neg_flag", cap_flag, 1'b0);
        issue(1, 3'd7, 1.0, 1.0, acc);
        wait_rsp();
        check_int("illegal_latency", cap_cyc - acc, 2);
        check_bit("illegal_err", cap_err, 1'b1);
        check_real("illegal_result", cap_res, 0.0, 0.0);

        // Backpressure: response held while req1 waits.
        bus.rsp_ready = 1'b0;
        issue(0, 3'd0, 1.5, 2.25, acc);
        wait_rsp();
        check_real("bp_result", cap_res, 3.75, 1e-12);
        set_req(1, 1'b1, 3'd1, 5.0, 2.0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_bit("bp_valid_held", bus.rsp_valid, 1'b1);
            check_bit("bp_busy", bus.busy, 1'b1);
            check_bit("bp_req1_ready", bus.req1_ready, 1'b0);
            check_real("bp_result_held", bus.rsp_result, cap_res, 0.0);
        end
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        h = cyc;
        wait_ready(1, acc);
        set_req(1, 1'b0, 3'd0, 0.0, 0.0);
        check_int("bp_next_accept", acc, h + 1);
        wait_rsp();
        check_real("bp_req1_result", cap_res, 3.0, 1e-12);
        check_bit("bp_req1_id", cap_id, 1'b1);

        // Reset during a divide from req0.
        issue(0, 3'd3, 8.0, 2.0, acc);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_bit("rst_mid_valid", bus.rsp_valid, 1'b0);
        check_bit("rst_mid_busy", bus.busy, 1'b0);
        check_bit("rst_mid_id", bus.rsp_id, 1'b0);
        check_bit("rst_mid_err", bus.rsp_err, 1'b0);
        check_bit("rst_mid_flag", bus.rsp_flag, 1'b0);
        check_real("rst_mid_result", bus.rsp_result, 0.0, 0.0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        check_int("rst_mid_no_rsp", seen, 0);
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 3'd0, 1.0, 1.0);
        set_req(1, 1'b1, 3'd0, 2.0, 2.0);
        @(negedge clk);
        check_bit("post_rst_req0_first", bus.req0_ready, 1'b1);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 3'd0, 0.0, 0.0);
        set_req(1, 1'b0, 3'd0, 0.0, 0.0);
        wait_rsp();
        check_real("post_rst_result", cap_res, 2.0, 1e-12);
        check_bit("post_rst_id", cap_id, 1'b0);
        repeat (3) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
